keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 matrix keypad and returns debounced hex key codes to the core logic. It is the input-side counterpart of the multiplexed 7-segment display path: a prescaled tick walks one active-low column strobe across the keypad, the returned rows are synchronised and debounced, and each accepted press produces a one-cycle strobe with its 4-bit code. It sits beside the display controller at top level, and its outputs feed the UART transmit path and the display data registers.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz
- SCAN_HZ, 1000, column-step rate in Hz; DIV = CLK_HZ/SCAN_HZ, integer, must be ≥ 4
- DEBOUNCE_SCANS, 4, number of consecutive agreeing samples needed to accept a press or a release; range 1–15

- clk_50Mhz  input  1  system clock
- reset  input  1  synchronous, active-low reset
- row  input  4  keypad row returns, active-low (pulled up off-chip), asynchronous
- col  output  4  column strobes, one-hot active-low
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_held  output  1  high while the accepted key is still down

## Operation
- Key map (col, row) to code:
  - col0, rows 0–3: 1, 4, 7, 0
  - col1, rows 0–3: 2, 5, 8, F
  - col2, rows 0–3: 3, 6, 9, E
  - col3, rows 0–3: A, B, C, D
- `row` passes through a 2-flop synchroniser. All decisions use the synchronised value `rs`.
- Prescaler counts 0..DIV-1 and wraps. `tick` is high for the one cycle where count == DIV-1.
- `hit` = any bit of `rs` is low. `hrow` = lowest-index low bit of `rs`. If several rows are low, the lowest row index wins.
- FSM states:
  - SCAN: on tick, if `hit`, latch cand_col = current column and cand_row = `hrow`, set cnt = 1, go to DEBOUNCE, and hold the column. Otherwise rotate the column: 1110 → 1101 → 1011 → 0111 → 1110.
  - DEBOUNCE: on tick, if `hit` and `hrow` == cand_row, increment cnt. When cnt reaches DEBOUNCE_SCANS, load key_code from the map, pulse key_valid, and go to HELD. On a mismatch or no hit, rotate the column and return to SCAN; no output changes.
  - HELD: key_held = 1. On tick, if rs[cand_row] is high, increment the release count. When it reaches DEBOUNCE_SCANS, clear key_held, rotate the column, and return to SCAN. If rs[cand_row] is low, clear the release count.
- DEBOUNCE_SCANS = 1: acceptance happens directly from SCAN on the first hit tick; release happens on the first high tick.
- key_code is retained until the next accepted press. It does not change on release.
- Other keys pressed while in HELD are ignored. The column does not move in DEBOUNCE or HELD.

## Timing
- Reset (reset = 0 at a clock edge) gives:
  - col = 4'b1110, key_code = 0, key_valid = 0, key_held = 0
  - prescaler = 0, state SCAN, counters 0
  - synchroniser flops = 4'b1111
- Reset mid-operation aborts any debounce or held state immediately. No key_valid is emitted for a key still down; after reset it is re-detected as a fresh press.
- All outputs are registered. Column changes take effect in the cycle after a tick, so each column is stable for DIV cycles before its sample. DIV ≥ 4 covers the 2-cycle synchroniser delay.
- Press latency: key_valid and key_held rise in the cycle after the tick carrying the DEBOUNCE_SCANS-th agreeing sample. key_code is valid in that same cycle.
- key_valid is exactly 1 cycle wide, with at most one pulse per press.
- Release latency: key_held falls in the cycle after the DEBOUNCE_SCANS-th consecutive high sample.
- Full column cycle with no key = 4·DIV cycles. At default parameters: DIV = 50000, 1 kHz step, 4 ms debounce.

## Test plan
Bench parameters: CLK_HZ = 100, SCAN_HZ = 10 (DIV = 10), DEBOUNCE_SCANS = 3. The keypad model pulls a row low when its key's column is low.

- Reset, then idle 100 cycles → col sequence 1110, 1101, 1011, 0111, 1110, each held 10 cycles; key_valid never asserts; key_held = 0.
- Hold key (col2, row1) → exactly one key_valid pulse with key_code = 6 in the cycle after the 3rd agreeing tick; key_held = 1; col stays 1011 while held.
- Release the key → key_held falls after 3 high ticks; scanning resumes at 0111; key_code stays 6.
- Bounce: key (col3, row3) low for 1 tick, high for 1, then stable → no pulse until 3 consecutive lows, then a single key_valid with key_code = D.
- Rows 0 and 2 both low on col1 → key_code = 2. While held, press (col0, row0) → no second pulse.
- Assert reset while in HELD with the key still down → outputs return to reset values next cycle. After deassertion the key is re-detected, giving one new key_valid after 3 agreeing ticks once col reaches the key's column.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, synchronises and
// debounces the row returns, and reports each accepted press as a hex code plus strobe.
module keypad_scanner #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_50Mhz,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int              DIV    = CLK_HZ / SCAN_HZ;
  localparam int              PW     = $clog2(DIV);
  localparam logic [PW-1:0]   DIV_M1 = PW'(DIV - 1);
  localparam logic [3:0]      DB     = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_meta, rs;
  logic [PW-1:0] presc;
  logic [3:0]    col_q, col_d;
  logic [1:0]    cand_col, cand_col_d, cand_row, cand_row_d;
  logic [3:0]    cnt, cnt_d, rel_cnt, rel_cnt_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d, held_q, held_d;
  logic          tick, hit;
  logic [1:0]    hrow, col_idx;
  logic [3:0]    rotated;

  function automatic logic [3:0] map_code(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    case ({c, r})
      4'h0: code = 4'h1;  4'h1: code = 4'h4;  4'h2: code = 4'h7;  4'h3: code = 4'h0;
      4'h4: code = 4'h2;  4'h5: code = 4'h5;  4'h6: code = 4'h8;  4'h7: code = 4'hF;
      4'h8: code = 4'h3;  4'h9: code = 4'h6;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
      4'hC: code = 4'hA;  4'hD: code = 4'hB;  4'hE: code = 4'hC;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick    = (presc == DIV_M1);
  assign hit     = ~&rs;
  assign rotated = {col_q[2:0], col_q[3]};

  // Lowest-index low row wins when several rows are pulled at once.
  always_comb begin
    hrow = 2'd3;
    if (!rs[2]) hrow = 2'd2;
    if (!rs[1]) hrow = 2'd1;
    if (!rs[0]) hrow = 2'd0;
    col_idx = 2'd3;
    if (!col_q[2]) col_idx = 2'd2;
    if (!col_q[1]) col_idx = 2'd1;
    if (!col_q[0]) col_idx = 2'd0;
  end

  // key_valid is a bare one-cycle strobe with no ready: the consumer must take
  // key_code in the cycle key_valid is high (key_code stays stable afterwards anyway).
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cand_col_d = cand_col;
    cand_row_d = cand_row;
    cnt_d      = cnt;
    rel_cnt_d  = rel_cnt;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    case (state_q)
      SCAN: if (tick) begin
        if (hit) begin
          cand_col_d = col_idx;
          cand_row_d = hrow;
          cnt_d      = 4'd1;
          rel_cnt_d  = 4'd0;
          if (DB == 4'd1) begin
            code_d  = map_code(col_idx, hrow);
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = HELD;
          end else begin
            state_d = DEBOUNCE;
          end
        end else begin
          col_d = rotated;
        end
      end
      DEBOUNCE: if (tick) begin
        if (hit && hrow == cand_row) begin
          cnt_d = cnt + 4'd1;
          if (cnt + 4'd1 == DB) begin
            code_d    = map_code(cand_col, cand_row);
            valid_d   = 1'b1;
            held_d    = 1'b1;
            rel_cnt_d = 4'd0;
            state_d   = HELD;
          end
        end else begin
          cnt_d   = 4'd0;
          col_d   = rotated;
          state_d = SCAN;
        end
      end
      HELD: if (tick) begin
        if (rs[cand_row]) begin
          rel_cnt_d = rel_cnt + 4'd1;
          if (rel_cnt + 4'd1 == DB) begin
            rel_cnt_d = 4'd0;
            cnt_d     = 4'd0;
            held_d    = 1'b0;
            col_d     = rotated;
            state_d   = SCAN;
          end
        end else begin
          rel_cnt_d = 4'd0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_50Mhz) begin
    if (!reset) begin
      row_meta <= 4'b1111;
      rs       <= 4'b1111;
      presc    <= '0;
      state_q  <= SCAN;
      col_q    <= 4'b1110;
      cand_col <= 2'd0;
      cand_row <= 2'd0;
      cnt      <= 4'd0;
      rel_cnt  <= 4'd0;
      code_q   <= 4'd0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
      presc    <= tick ? '0 : presc + PW'(1);
      state_q  <= state_d;
      col_q    <= col_d;
      cand_col <= cand_col_d;
      cand_row <= cand_row_d;
      cnt      <= cnt_d;
      rel_cnt  <= rel_cnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
